// File: rtl/task_stream_input.sv
// Packet-buffering stream input: loads one upstream packet into a circular buffer, then replays it downstream.
// Optional build macro TASK_STREAM_INPUT_DONE_HANDSHAKE_EN makes each new packet wait for i_out_done.
module task_stream_input #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_tvalid,
    input  logic [DATA_W-1:0]         i_tdata,
    input  logic                      i_tlast,
    output logic                      o_tready,
    output logic [DATA_W-1:0]         o_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic                      o_last,
    input  logic                      i_out_done,
    output logic [$clog2(DEPTH):0]    o_len,
    output logic                      o_busy,
    output logic                      o_empty,
    output logic                      o_err
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LEN_W = AW + 1;
    localparam logic [AW:0]   FULL_CNT = LEN_W'(DEPTH);
    localparam logic [AW:0]   ONE_CNT  = LEN_W'(1);
    localparam logic [AW-1:0] ONE_PTR  = AW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_LOAD,
        S_SEND,
        S_WAIT
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [AW:0]         r_count;
    logic [AW:0]         r_len;
    logic                r_err;
    logic                w_accept;
    logic                w_write;
    logic                w_drop;
    logic                w_read;
    logic                w_empty;
    logic                w_last_beat;
    logic                w_enter_req;
    logic                w_wait_release;

    assign w_empty     = (r_count == '0);
    assign w_accept    = (r_state == S_LOAD) && i_tvalid;
    assign w_write     = w_accept && (r_count != FULL_CNT);
    assign w_drop      = w_accept && (r_count == FULL_CNT);
    assign w_last_beat = (r_count == ONE_CNT);
    assign w_read      = (r_state == S_SEND) && !w_empty && i_ready;
    assign w_enter_req = (w_next == S_REQ);

`ifdef TASK_STREAM_INPUT_DONE_HANDSHAKE_EN
    logic r_done;

    // Done flag remembers a downstream completion seen any time before the next request phase.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_done <= 1'b0;
        end else if (w_enter_req) begin
            r_done <= 1'b0;
        end else if (i_out_done && (r_state != S_REQ)) begin
            r_done <= 1'b1;
        end
    end

    assign w_wait_release = r_done;
`else
    logic w_unused_done;

    assign w_unused_done  = i_out_done;
    assign w_wait_release = 1'b1;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = S_REQ;
            S_REQ:   w_next = S_LOAD;
            S_LOAD:  if (w_accept && i_tlast) w_next = S_SEND;
            S_SEND:  if (w_read && w_last_beat) w_next = S_WAIT;
            S_WAIT:  if (w_wait_release) w_next = S_REQ;
            default: w_next = S_IDLE;
        endcase
    end

    // Storage array carries no reset so it can map onto RAM; occupancy tracking makes stale words invisible.
    always_ff @(posedge i_clk) begin
        if (w_write) begin
            r_mem[r_wptr] <= i_tdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_write) begin
                r_wptr  <= r_wptr + ONE_PTR;
                r_count <= r_count + ONE_CNT;
            end else if (w_read) begin
                r_rptr  <= r_rptr + ONE_PTR;
                r_count <= r_count - ONE_CNT;
            end
        end
    end

    // Packet length and overflow flag describe the packet loaded since the last request phase.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_len <= '0;
            r_err <= 1'b0;
        end else if (w_enter_req) begin
            r_len <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_write && (r_len != FULL_CNT)) begin
                r_len <= r_len + ONE_CNT;
            end
            if (w_drop) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_tready = (r_state == S_LOAD);
    assign o_valid  = (r_state == S_SEND) && !w_empty;
    assign o_data   = r_mem[r_rptr];
    assign o_last   = o_valid && w_last_beat;
    assign o_len    = r_len;
    assign o_busy   = (r_state == S_LOAD) || (r_state == S_SEND);
    assign o_empty  = w_empty;
    assign o_err    = r_err;

endmodule

// File: tb/tb_task_stream_input.sv
// Self-checking bench for task_stream_input: queue-based packet model, directed scenarios and random traffic.
module tb_task_stream_input;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_tvalid;
    logic [DATA_W-1:0] i_tdata;
    logic              i_tlast;
    logic              o_tready;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              i_ready;
    logic              o_last;
    logic              i_out_done;
    logic [4:0]        o_len;
    logic              o_busy;
    logic              o_empty;
    logic              o_err;

    int checks = 0;
    int errors = 0;
    bit cmpEn  = 1'b0;

    task_stream_input #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_tvalid   (i_tvalid),
        .i_tdata    (i_tdata),
        .i_tlast    (i_tlast),
        .o_tready   (o_tready),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_last     (o_last),
        .i_out_done (i_out_done),
        .o_len      (o_len),
        .o_busy     (o_busy),
        .o_empty    (o_empty),
        .o_err      (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [7:0] d, input bit l, input bit r, input bit dn);
        i_tvalid   = v;
        i_tdata    = d;
        i_tlast    = l;
        i_ready    = r;
        i_out_done = dn;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Packet-level model: a beat queue plus a few phase flags and a countdown to the next load window.
    logic [7:0] mQ[$];
    int mLen      = 0;
    bit mErr      = 1'b0;
    bit mDone     = 1'b0;
    bit mInLoad   = 1'b0;
    bit mInSend   = 1'b0;
    bit mInWait   = 1'b0;
    int mPreLoad  = 2;

    always @(posedge i_clk) begin
        bit entReq;
        bit wasReq;
        bit doneOk;
        if (i_rst) begin
            mQ.delete();
            mLen     = 0;
            mErr     = 1'b0;
            mDone    = 1'b0;
            mInLoad  = 1'b0;
            mInSend  = 1'b0;
            mInWait  = 1'b0;
            mPreLoad = 2;
        end else begin
`ifdef TASK_STREAM_INPUT_DONE_HANDSHAKE_EN
            doneOk = mDone;
`else
            doneOk = 1'b1;
`endif
            entReq = (mPreLoad == 2) || (mInWait && doneOk);
            wasReq = (mPreLoad == 1);
            if (entReq) mDone = 1'b0;
            else if (!wasReq && i_out_done) mDone = 1'b1;
            if (mInLoad && i_tvalid) begin
                if (mQ.size() < DEPTH) begin
                    mQ.push_back(i_tdata);
                    mLen++;
                end else begin
                    mErr = 1'b1;
                end
                if (i_tlast) begin
                    mInLoad = 1'b0;
                    mInSend = 1'b1;
                end
            end else if (mInSend && mQ.size() > 0 && i_ready) begin
                void'(mQ.pop_front());
                if (mQ.size() == 0) begin
                    mInSend = 1'b0;
                    mInWait = 1'b1;
                end
            end
            if (wasReq) begin
                mPreLoad = 0;
                mInLoad  = 1'b1;
            end
            if (entReq) begin
                mPreLoad = 1;
                mInWait  = 1'b0;
                mLen     = 0;
                mErr     = 1'b0;
            end
        end
    end

    // Every cycle, compare all outputs against the model halfway between active edges.
    always @(negedge i_clk) begin
        bit expValid;
        if (cmpEn) begin
            expValid = mInSend && (mQ.size() > 0);
            checkOutput("tready", o_tready, mInLoad);
            checkOutput("valid",  o_valid,  expValid);
            checkOutput("last",   o_last,   expValid && (mQ.size() == 1));
            checkOutput("busy",   o_busy,   mInLoad || mInSend);
            checkOutput("empty",  o_empty,  mQ.size() == 0);
            checkOutput("err",    o_err,    mErr);
            checkOutput("len",    o_len,    mLen);
            if (expValid) checkOutput("data", o_data, mQ[0]);
        end
    end

    initial begin
        logic [7:0] pkt3[3]     = '{8'h11, 8'h22, 8'h33};
        bit         readyPat[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] expData[5]  = '{8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
        bit         expLast[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int         cnt;

        i_rst = 1'b1;
        applyStimulus(0, 8'h00, 0, 0, 0);
        tick();
        cmpEn = 1'b1;
        tick();
        tick();
        checkOutput("rst_tready", o_tready, 0);
        checkOutput("rst_empty",  o_empty,  1);
        checkOutput("rst_len",    o_len,    0);

        i_rst = 1'b0;
        tick();
        checkOutput("rel1_tready", o_tready, 0);
        checkOutput("rel1_valid",  o_valid,  0);
        checkOutput("rel1_empty",  o_empty,  1);
        tick();
        checkOutput("rel2_tready", o_tready, 1);

        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, pkt3[k], k == 2, 0, 0);
            tick();
        end
        applyStimulus(0, 8'h00, 0, 0, 0);
        checkOutput("p3_len",    o_len,    3);
        checkOutput("p3_valid",  o_valid,  1);
        checkOutput("p3_head",   o_data,   8'h11);
        checkOutput("p3_tready", o_tready, 0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 8'h00, 0, readyPat[i], i == 1);
            checkOutput("stall_data", o_data,  expData[i]);
            checkOutput("stall_last", o_last,  expLast[i]);
            checkOutput("stall_valid", o_valid, 1);
            tick();
        end
        applyStimulus(0, 8'h00, 0, 0, 0);
        checkOutput("wait_valid", o_valid, 0);
        checkOutput("wait_busy",  o_busy,  0);
        checkOutput("wait_len",   o_len,   3);
        tick();
        checkOutput("req_tready", o_tready, 0);
        checkOutput("req_len",    o_len,    0);
        tick();
        checkOutput("reload_tready", o_tready, 1);

        for (int k = 0; k < 20; k++) begin
            applyStimulus(1, 8'h40 + 8'(k), k == 19, 0, 0);
            tick();
        end
        checkOutput("big_len",  o_len,  16);
        checkOutput("big_err",  o_err,  1);
        checkOutput("big_head", o_data, 8'h40);
        cnt = 0;
        applyStimulus(0, 8'h00, 0, 1, 1);
        for (int c = 0; c < 64; c++) begin
            if (o_valid) cnt++;
            tick();
            applyStimulus(0, 8'h00, 0, 1, 0);
            if (!o_busy) break;
        end
        checkOutput("big_beats_out", cnt, 16);
        checkOutput("big_err_wait",  o_err, 1);
        applyStimulus(0, 8'h00, 0, 0, 0);
        tick();
        checkOutput("big_err_req", o_err, 0);
        checkOutput("big_len_req", o_len, 0);
        tick();

        for (int k = 0; k < 8; k++) begin
            applyStimulus(1, 8'h80 + 8'(k), k == 7, 0, 0);
            tick();
        end
        applyStimulus(0, 8'h00, 0, 1, 0);
        repeat (3) tick();
        applyStimulus(0, 8'h00, 0, 0, 0);
        checkOutput("mid_head", o_data, 8'h83);
        i_rst = 1'b1;
        tick();
        checkOutput("mid_rst_empty",  o_empty,  1);
        checkOutput("mid_rst_valid",  o_valid,  0);
        checkOutput("mid_rst_tready", o_tready, 0);
        i_rst = 1'b0;
        tick();
        checkOutput("mid_rel1_tready", o_tready, 0);
        tick();
        checkOutput("mid_rel2_tready", o_tready, 1);

        for (int c = 0; c < 3000; c++) begin
            i_rst = ($urandom_range(0, 399) == 0);
            applyStimulus($urandom_range(0, 1) == 1, 8'($urandom),
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 5) == 0);
            tick();
        end
        i_rst = 1'b0;
        applyStimulus(0, 8'h00, 0, 0, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
